// File: rtl/instr_register_pkg.sv
// Types shared by the instruction register and its result checker.
package instr_register_pkg;

    localparam int DEPTH   = 32;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int COUNT_W = ADDR_W + 1;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7,
        POW   = 4'd8
    } opcode_t;

    typedef logic [15:0]       operand_t;
    typedef logic [31:0]       result_t;
    typedef logic [ADDR_W-1:0] address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  res;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CHECK,
        PRESENT,
        FINISH
    } checker_state_t;

endpackage

// File: rtl/instr_expect_calc.sv
// Combinational golden result for one instruction entry, truncated to result_t.
module instr_expect_calc
    import instr_register_pkg::*;
(
    input  opcode_t  opc,
    input  operand_t a,
    input  operand_t b,
    output result_t  expected,
    output logic     legal
);

    result_t a_ext;
    result_t b_ext;
    result_t pow_acc;
    result_t pow_base;

    // Square-and-multiply keeps the exponent logic bounded by the operand width.
    always_comb begin
        a_ext    = result_t'(a);
        b_ext    = result_t'(b);
        pow_acc  = result_t'(1);
        pow_base = a_ext;
        for (int i = 0; i < $bits(operand_t); i++) begin
            if (b[i]) pow_acc = pow_acc * pow_base;
            pow_base = pow_base * pow_base;
        end
    end

    always_comb begin
        expected = '0;
        legal    = 1'b1;
        case (opc)
            ZERO:    expected = '0;
            PASSA:   expected = a_ext;
            PASSB:   expected = b_ext;
            ADD:     expected = a_ext + b_ext;
            SUB:     expected = a_ext - b_ext;
            MULT:    expected = a_ext * b_ext;
            DIV:     expected = (b == '0) ? '0 : a_ext / b_ext;
            MOD:     expected = (b == '0) ? '0 : a_ext % b_ext;
            POW:     expected = pow_acc;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_result_checker.sv
// Sweeps a window of the instruction register and streams pass/fail records.
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | read_pointer stable, register read settling
// CHECK   | capture entry and compare against recomputed result
// PRESENT | record valid, waiting for res_ready
// FINISH  | sweep complete, done pulses next cycle
module instr_result_checker #(
    parameter int CNT_W = 16,
    parameter int DEPTH = instr_register_pkg::DEPTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  instr_register_pkg::address_t   first_ptr,
    input  logic [$clog2(DEPTH):0]         count,
    output instr_register_pkg::address_t   read_pointer,
    input  instr_register_pkg::instruction_t instruction_word,
    output logic                           res_valid,
    input  logic                           res_ready,
    output instr_register_pkg::address_t   res_ptr,
    output logic                           res_pass,
    output instr_register_pkg::result_t    res_expected,
    output instr_register_pkg::instruction_t res_word,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               pass_cnt,
    output logic [CNT_W-1:0]               fail_cnt
);

    import instr_register_pkg::*;

    typedef logic [$clog2(DEPTH):0] count_t;

    checker_state_t state;
    checker_state_t state_next;
    count_t         remaining;
    result_t        calc_expected;
    logic           calc_legal;
    logic           accept_start;
    logic           handshake;
    logic           last_entry;

    instr_expect_calc u_calc (
        .opc      (instruction_word.opc),
        .a        (instruction_word.op_a),
        .b        (instruction_word.op_b),
        .expected (calc_expected),
        .legal    (calc_legal)
    );

    assign last_entry = (remaining == count_t'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        handshake    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = (count != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE:   state_next = CHECK;
            CHECK:   state_next = PRESENT;
            PRESENT: begin
                if (res_ready) begin
                    handshake  = 1'b1;
                    state_next = last_entry ? FINISH : ISSUE;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer <= '0;
            remaining    <= '0;
            res_valid    <= 1'b0;
            res_ptr      <= '0;
            res_pass     <= 1'b0;
            res_expected <= '0;
            res_word     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
        end else begin
            done <= (state == FINISH);
            if (accept_start) begin
                read_pointer <= first_ptr;
                remaining    <= count;
                pass_cnt     <= '0;
                fail_cnt     <= '0;
                busy         <= (count != '0);
            end
            if (state == CHECK) begin
                res_word     <= instruction_word;
                res_expected <= calc_expected;
                res_pass     <= calc_legal && (instruction_word.res === calc_expected);
                res_ptr      <= read_pointer;
                res_valid    <= 1'b1;
            end
            if (handshake) begin
                res_valid    <= 1'b0;
                remaining    <= remaining - count_t'(1);
                read_pointer <= (read_pointer == address_t'(DEPTH - 1)) ? '0 : read_pointer + 1'b1;
                if (res_pass) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                end
                if (last_entry) busy <= 1'b0;
            end
        end
    end

endmodule
